// File: rtl/ranc_core_pkg.sv
// Shared types and default sizing for the RANC core axon/synapse datapath.
package ranc_core_pkg;

    localparam int unsigned NUM_AXONS_DEF    = 256;
    localparam int unsigned NUM_NEURONS_DEF  = 256;
    localparam int unsigned DONE_TIMEOUT_DEF = 16;

    localparam int unsigned AXON_W   = $clog2(NUM_AXONS_DEF);
    localparam int unsigned NEURON_W = $clog2(NUM_NEURONS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEARCH    = 3'd1,
        ST_SWEEP     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } disp_state_e;

endpackage

// File: rtl/axon_spike_dispatcher_if.sv
// Dispatcher <-> core/synapse-connection handshake bundle.
// dispatch_err exists only when DISPATCH_TIMEOUT_EN is defined.
interface axon_spike_dispatcher_if
    import ranc_core_pkg::*;
#(
    parameter int unsigned NUM_AXONS = NUM_AXONS_DEF
);
    localparam int unsigned AW = $clog2(NUM_AXONS);
    localparam int unsigned CW = $clog2(NUM_AXONS + 1);

    logic                 tick;
    logic [NUM_AXONS-1:0] spikes_in;
    logic                 synap_con_done;
    logic [AW-1:0]        axon_number;
    logic                 enable;
    logic                 busy;
    logic                 tick_done;
    logic [CW-1:0]        spike_count;
`ifdef DISPATCH_TIMEOUT_EN
    logic                 dispatch_err;
`endif

    modport master (
        input  tick, spikes_in, synap_con_done,
`ifdef DISPATCH_TIMEOUT_EN
        output dispatch_err,
`endif
        output axon_number, enable, busy, tick_done, spike_count
    );

    modport slave (
        output tick, spikes_in, synap_con_done,
`ifdef DISPATCH_TIMEOUT_EN
        input  dispatch_err,
`endif
        input  axon_number, enable, busy, tick_done, spike_count
    );

endinterface

// File: rtl/spike_priority_enc.sv
// Combinational lowest-set-bit encoder over the pending spike vector.
module spike_priority_enc #(
    parameter int unsigned NUM_AXONS = 256
) (
    input  logic [NUM_AXONS-1:0]         i_pending,
    output logic                         o_found_c,
    output logic [$clog2(NUM_AXONS)-1:0] o_idx_c
);
    localparam int unsigned AW = $clog2(NUM_AXONS);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_found_c = 1'b0;
        o_idx_c   = '0;
        for (int i = int'(NUM_AXONS) - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_found_c = 1'b1;
                o_idx_c   = AW'(i);
            end
        end
    end

endmodule

// File: rtl/axon_spike_dispatcher.sv
// Walks a tick's spiking axons lowest-first, holding enable for one neuron sweep each.
// Optional WAIT_DONE timeout with sticky dispatch_err: define DISPATCH_TIMEOUT_EN.
module axon_spike_dispatcher
    import ranc_core_pkg::*;
#(
    parameter int unsigned NUM_AXONS    = NUM_AXONS_DEF,
    parameter int unsigned NUM_NEURONS  = NUM_NEURONS_DEF
`ifdef DISPATCH_TIMEOUT_EN
    ,
    parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    axon_spike_dispatcher_if.master bus
);
    localparam int unsigned AW = $clog2(NUM_AXONS);
    localparam int unsigned CW = $clog2(NUM_AXONS + 1);
    localparam int unsigned SW = $clog2(NUM_NEURONS) + 1;

    disp_state_e          r_state, w_state_nxt;
    logic [NUM_AXONS-1:0] r_pending, w_pending_nxt;
    logic [AW-1:0]        r_axon_number, w_axon_nxt;
    logic                 r_enable, w_enable_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_tick_done, w_tick_done_nxt;
    logic [CW-1:0]        r_spike_count, w_count_nxt;
    logic [SW-1:0]        r_sweep_cnt, w_sweep_nxt;
    logic                 r_done_seen, w_seen_nxt;
    logic                 w_found;
    logic [AW-1:0]        w_idx;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(DONE_TIMEOUT) + 1;
    logic [TW-1:0]        r_to_cnt, w_to_nxt;
    logic                 r_err, w_err_nxt;
`endif

    spike_priority_enc #(.NUM_AXONS(NUM_AXONS)) u_enc (
        .i_pending (r_pending),
        .o_found_c (w_found),
        .o_idx_c   (w_idx)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_axon_nxt      = r_axon_number;
        w_enable_nxt    = r_enable;
        w_tick_done_nxt = 1'b0;
        w_count_nxt     = r_spike_count;
        w_sweep_nxt     = r_sweep_cnt;
        w_seen_nxt      = r_done_seen;
`ifdef DISPATCH_TIMEOUT_EN
        w_to_nxt        = r_to_cnt;
        w_err_nxt       = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.tick) begin
                    w_pending_nxt = bus.spikes_in;
                    w_count_nxt   = '0;
                    w_state_nxt   = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_found) begin
                    w_axon_nxt    = w_idx;
                    w_pending_nxt = r_pending & ~(NUM_AXONS'(1) << w_idx);
                    w_count_nxt   = r_spike_count + CW'(1);
                    w_enable_nxt  = 1'b1;
                    w_sweep_nxt   = '0;
                    w_seen_nxt    = 1'b0;
                    w_state_nxt   = ST_SWEEP;
                end else begin
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_SWEEP: begin
                w_sweep_nxt = r_sweep_cnt + SW'(1);
                // Last enabled cycle: an early done pulse here is remembered.
                if (r_sweep_cnt == SW'(NUM_NEURONS - 1)) begin
                    w_enable_nxt = 1'b0;
                    w_seen_nxt   = bus.synap_con_done;
                    w_state_nxt  = ST_WAIT_DONE;
`ifdef DISPATCH_TIMEOUT_EN
                    w_to_nxt     = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (bus.synap_con_done || r_done_seen) begin
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = ST_SEARCH;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (r_to_cnt == TW'(DONE_TIMEOUT - 1)) begin
                    w_err_nxt     = 1'b1;
                    w_pending_nxt = '0;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_to_nxt = r_to_cnt + TW'(1);
                end
`endif
            end
            ST_DONE: begin
                w_tick_done_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_axon_number <= '0;
            r_enable      <= 1'b0;
            r_busy        <= 1'b0;
            r_tick_done   <= 1'b0;
            r_spike_count <= '0;
            r_sweep_cnt   <= '0;
            r_done_seen   <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pending     <= w_pending_nxt;
            r_axon_number <= w_axon_nxt;
            r_enable      <= w_enable_nxt;
            r_busy        <= w_busy_nxt;
            r_tick_done   <= w_tick_done_nxt;
            r_spike_count <= w_count_nxt;
            r_sweep_cnt   <= w_sweep_nxt;
            r_done_seen   <= w_seen_nxt;
`ifdef DISPATCH_TIMEOUT_EN
            r_to_cnt      <= w_to_nxt;
            r_err         <= w_err_nxt;
`endif
        end
    end

    assign bus.axon_number = r_axon_number;
    assign bus.enable      = r_enable;
    assign bus.busy        = r_busy;
    assign bus.tick_done   = r_tick_done;
    assign bus.spike_count = r_spike_count;
`ifdef DISPATCH_TIMEOUT_EN
    assign bus.dispatch_err = r_err;
`endif

endmodule

// File: tb/tb_axon_spike_dispatcher.sv
// Directed bench for axon_spike_dispatcher with a simple synapse-side responder.
module tb_axon_spike_dispatcher;
    import ranc_core_pkg::*;

    localparam int unsigned NA        = 256;
    localparam int unsigned SWEEP_LEN = 1 << NEURON_W;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    axon_spike_dispatcher_if #(.NUM_AXONS(NA)) bus ();

    axon_spike_dispatcher #(.NUM_AXONS(NA), .NUM_NEURONS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor state plus a responder pulsing synap_con_done when enable falls.
    bit respond;
    bit prev_en;
    bit seen_sweep;
    int cyc;
    int sw_axon[$];
    int sw_len[$];
    int cur_len, unstable, gap, min_gap, td_cnt, last_fall, td_cyc;

    always @(negedge clk) begin
        cyc++;
        bus.synap_con_done = 1'b0;
        if (bus.enable && !prev_en) begin
            if (seen_sweep && gap < min_gap) min_gap = gap;
            sw_axon.push_back(int'(bus.axon_number));
            cur_len    = 1;
            seen_sweep = 1'b1;
        end else if (bus.enable) begin
            cur_len++;
            if (int'(bus.axon_number) != sw_axon[$]) unstable++;
        end else if (prev_en) begin
            sw_len.push_back(cur_len);
            gap       = 1;
            last_fall = cyc;
            if (respond) bus.synap_con_done = 1'b1;
        end else begin
            gap++;
        end
        if (bus.tick_done) begin
            td_cnt++;
            td_cyc = cyc;
        end
        prev_en = bus.enable;
    end

    task automatic clear_mon();
        sw_axon.delete();
        sw_len.delete();
        unstable   = 0;
        min_gap    = 1000;
        seen_sweep = 1'b0;
        td_cnt     = 0;
        gap        = 0;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Returns at the negedge following the accepting edge.
    task automatic send_tick(input logic [NA-1:0] vec);
        @(negedge clk);
        bus.tick      = 1'b1;
        bus.spikes_in = vec;
        @(negedge clk);
        bus.tick      = 1'b0;
    endtask

    task automatic wait_tick_done(input int budget, input string tag);
        int n = 0;
        while (!bus.tick_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tick_done_seen"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        logic [NA-1:0] v;
        int bad_order, bad_len;

        rst           = 1'b0;
        bus.tick      = 1'b0;
        bus.spikes_in = '0;
        respond       = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_axon",  32'(bus.axon_number), 32'd0);
        check("rst_en",    32'(bus.enable),      32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_td",    32'(bus.tick_done),   32'd0);
        check("rst_count", 32'(bus.spike_count), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Test 1: reset held 3 cycles mid-sweep
        v = '0; v[5] = 1'b1;
        send_tick(v);
        repeat (10) @(negedge clk);
        check("t1_mid_en", 32'(bus.enable), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t1_en",    32'(bus.enable),      32'd0);
        check("t1_busy",  32'(bus.busy),        32'd0);
        check("t1_count", 32'(bus.spike_count), 32'd0);
        check("t1_axon",  32'(bus.axon_number), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1 clear_mon();
        send_tick('0);
        wait_tick_done(20, "t1");
        check("t1_after_count", 32'(bus.spike_count), 32'd0);
        check("t1_after_sweeps", 32'(sw_axon.size()), 32'd0);

        // Test 2: empty vector, exact tick_done latency
        repeat (2) @(negedge clk);
        #1 clear_mon();
        send_tick('0);
        check("t2_td_e1",   32'(bus.tick_done), 32'd0);
        check("t2_busy_e1", 32'(bus.busy),      32'd1);
        @(negedge clk);
        check("t2_td_e2",   32'(bus.tick_done), 32'd0);
        @(negedge clk);
        check("t2_td_e3",   32'(bus.tick_done), 32'd1);
        check("t2_count",   32'(bus.spike_count), 32'd0);
        check("t2_busy_e3", 32'(bus.busy),      32'd0);
        repeat (3) @(negedge clk);
        check("t2_sweeps",  32'(sw_axon.size()), 32'd0);
        check("t2_td_cnt",  32'(td_cnt),          32'd1);

        // Test 3: single axon 5
        #1 clear_mon();
        v = '0; v[5] = 1'b1;
        send_tick(v);
        wait_tick_done(2000, "t3");
        repeat (3) @(negedge clk);
        check("t3_sweeps",   32'(sw_axon.size()),  32'd1);
        check("t3_axon",     32'(q_at(sw_axon, 0)), 32'd5);
        check("t3_len",      32'(q_at(sw_len, 0)),  32'(SWEEP_LEN));
        check("t3_count",    32'(bus.spike_count), 32'd1);
        check("t3_td_cnt",   32'(td_cnt),          32'd1);
        check("t3_unstable", 32'(unstable),        32'd0);

        // Test 4: axons 0 and 255
        #1 clear_mon();
        v = '0; v[0] = 1'b1; v[NA-1] = 1'b1;
        send_tick(v);
        wait_tick_done(2000, "t4");
        repeat (3) @(negedge clk);
        check("t4_sweeps", 32'(sw_axon.size()),   32'd2);
        check("t4_axon0",  32'(q_at(sw_axon, 0)), 32'd0);
        check("t4_axon1",  32'(q_at(sw_axon, 1)), 32'd255);
        check("t4_len0",   32'(q_at(sw_len, 0)),  32'(SWEEP_LEN));
        check("t4_len1",   32'(q_at(sw_len, 1)),  32'(SWEEP_LEN));
        check("t4_gap_ge2", 32'(min_gap >= 2),    32'd1);
        check("t4_count",  32'(bus.spike_count),  32'd2);

        // Test 5: all axons, with an extra tick while busy
        #1 clear_mon();
        v = '1;
        send_tick(v);
        repeat (1000) @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        wait_tick_done(80000, "t5");
        repeat (3) @(negedge clk);
        bad_order = 0;
        bad_len   = 0;
        for (int i = 0; i < sw_axon.size(); i++) begin
            if (sw_axon[i] != i) bad_order++;
            if (q_at(sw_len, i) != int'(SWEEP_LEN)) bad_len++;
        end
        check("t5_sweeps",    32'(sw_axon.size()),  32'd256);
        check("t5_bad_order", 32'(bad_order),       32'd0);
        check("t5_bad_len",   32'(bad_len),         32'd0);
        check("t5_count",     32'(bus.spike_count), 32'd256);
        check("t5_td_cnt",    32'(td_cnt),          32'd1);
        check("t5_busy",      32'(bus.busy),        32'd0);
        check("t5_unstable",  32'(unstable),        32'd0);

`ifdef DISPATCH_TIMEOUT_EN
        // Test 6: no done response, timeout abandons axon 7
        respond = 1'b0;
        #1 clear_mon();
        v = '0; v[3] = 1'b1; v[7] = 1'b1;
        send_tick(v);
        wait_tick_done(2000, "t6");
        check("t6_td_latency", 32'(td_cyc - last_fall), 32'd17);
        check("t6_err",        32'(bus.dispatch_err),   32'd1);
        repeat (3) @(negedge clk);
        check("t6_sweeps",     32'(sw_axon.size()),     32'd1);
        check("t6_axon",       32'(q_at(sw_axon, 0)),   32'd3);
        check("t6_count",      32'(bus.spike_count),    32'd1);
        check("t6_td_cnt",     32'(td_cnt),             32'd1);
        check("t6_err_sticky", 32'(bus.dispatch_err),   32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_err_rst",    32'(bus.dispatch_err),   32'd0);
        @(negedge clk) rst = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axon_spike_dispatcher.md
Name: axon_spike_dispatcher

Overview:
- Initiator side of the axon-to-synapse scan interface.
- On each tick, latches the core's incoming axon spike vector and walks the set bits lowest-index-first.
- For each spiking axon, drives `axon_number` with `enable` held for one full neuron sweep, then waits for the synapse connection block's `synap_con_done` before the next axon.
- Signals `tick_done` when every spiking axon has been swept.

Parameters:
- NUM_AXONS, 256, number of axon inputs; width of the spike vector.
- NUM_NEURONS, 256, sweep length; cycles `enable` is held per axon.
- DONE_TIMEOUT, 16, max cycles in WAIT_DONE before error; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk; 0 = reset.
- tick  in  1  start pulse; accepted only in IDLE.
- spikes_in  in  NUM_AXONS  spike vector; bit i = axon i spiked; sampled on the accepted tick.
- synap_con_done  in  1  sweep-complete pulse from the synapse connection block.
- axon_number  out  clog2(NUM_AXONS)  axon currently being swept.
- enable  out  1  sweep enable to the synapse connection block.
- busy  out  1  high whenever state != IDLE.
- tick_done  out  1  one-cycle pulse when the tick's dispatch completes.
- spike_count  out  clog2(NUM_AXONS+1)  axons dispatched in the current/last tick.
- dispatch_err  out  1  sticky timeout flag; port exists only with DISPATCH_TIMEOUT_EN.

Behaviour:
- Reset (rst=0 at an edge) forces all of the following, regardless of current state:
  - `axon_number`=0, `enable`=0, `busy`=0, `tick_done`=0, `spike_count`=0, `dispatch_err`=0.
  - pending register cleared, sweep counter=0, state=IDLE.
  - Reset mid-dispatch drops `enable` at that same edge.
- Registers: `pending[NUM_AXONS-1:0]`; `sweep_cnt` of width clog2(NUM_NEURONS)+1. All outputs are registered.
- IDLE:
  - tick=1 → pending<=spikes_in, spike_count<=0, go SEARCH.
  - tick=0 → hold.
- SEARCH (exactly 1 cycle):
  - Priority encoder finds the lowest set bit of pending.
  - If found: axon_number<=idx, clear pending[idx], spike_count+=1, enable<=1, sweep_cnt<=0, go SWEEP.
  - If pending==0: go DONE.
- SWEEP:
  - `enable` stays high and `axon_number` stays stable; sweep_cnt increments each cycle.
  - `enable` is high for exactly NUM_NEURONS consecutive cycles. On the last of them, enable<=0 and go WAIT_DONE.
  - `enable` is never high on the cycle `synap_con_done` is registered, so the downstream neuron counter parks at 0.
- WAIT_DONE:
  - synap_con_done=1 → go SEARCH.
  - A `synap_con_done` seen during SWEEP's final cycle is captured in a flag and counts as received; WAIT_DONE then lasts 1 cycle.
- DONE: tick_done=1 for one cycle, then IDLE. `spike_count` holds until the next accepted tick.
- Boundary conditions:
  - tick while busy: ignored, no effect on pending or count.
  - spikes_in all zero: tick accepted at edge E; SEARCH at E+1; DONE visible after E+2; tick_done high for the cycle after edge E+2; `enable` never asserts.
  - All NUM_AXONS bits set: spike_count reaches NUM_AXONS with no overflow, because its width is clog2(NUM_AXONS+1).
  - Axon index NUM_AXONS-1 is encoded correctly (full-width index).
  - Sequencing: `enable` drops for at least 1 cycle (WAIT_DONE) plus 1 cycle (SEARCH) between consecutive axons.

Optional Feature:
- Macro `DISPATCH_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_DONE.
  - If `synap_con_done` is not seen within DONE_TIMEOUT cycles: `dispatch_err`<=1 (sticky until reset), pending cleared, go DONE (tick_done still pulses).
- Undefined: WAIT_DONE waits indefinitely; the `dispatch_err` port and counter are absent.

Decomposition:
- Shared package `ranc_core_pkg`:
  - state encoding IDLE/SEARCH/SWEEP/WAIT_DONE/DONE.
  - AXON_W = clog2(NUM_AXONS), NEURON_W = clog2(NUM_NEURONS).
  - default DONE_TIMEOUT.
- One sub-module, `spike_priority_enc`: combinational lowest-set-bit encoder giving `found` and `idx` from pending; parameterised by NUM_AXONS.

Test Plan:
1. Reset held 3 cycles mid-SWEEP → enable=0, busy=0, spike_count=0 after the first reset edge; a subsequent tick with spikes_in=0 completes normally.
2. tick with spikes_in=0 → tick_done pulses exactly 2 cycles after the tick edge; enable never 1; spike_count=0.
3. spikes_in bit 5 only; model returns synap_con_done 1 cycle after enable falls → axon_number=5, enable high exactly 256 cycles, tick_done pulses once, spike_count=1.
4. spikes_in bits {0,255} → first sweep axon_number=0, second axon_number=255 (ascending order); enable low ≥2 cycles between sweeps; spike_count=2.
5. spikes_in all ones (256 axons) → 256 sweeps in ascending order; spike_count=256; a second tick asserted during busy is ignored (no extra sweeps).
6. With DISPATCH_TIMEOUT_EN, synap_con_done held 0, spikes_in bits {3,7} → after axon 3's sweep plus 16 cycles, dispatch_err=1 and tick_done pulses; axon 7 is never dispatched; spike_count=1.
